// File: rtl/regfile_operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage: default widths, the bit
// positions of the rs1/rs2 fields in an RV32 instruction, and the stage FSM
// state encoding.
package regfile_operand_fetch_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int INSTR_W  = 32;
  localparam int RS1_LSB  = 15;
  localparam int RS2_LSB  = 20;

  // EMPTY: nothing presented. FRESH: operands come from the RAM read issued in
  // the accept cycle. HELD: execute stalled, operands come from hold registers.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FRESH = 2'd1,
    ST_HELD  = 2'd2
  } state_e;

endpackage

// File: rtl/regfile_operand_fetch_bypass_mux.sv
// operand_bypass_mux: builds one source operand (rs1 or rs2) for the
// operand-fetch stage.
//   clk, rstn     clock, asynchronous active-low reset
//   accept_i      instruction accepted this cycle
//   fresh_i       stage is in FRESH (RAM read data is current)
//   hold_en_i     stage holds its output into the next cycle
//   rs_in_i       source register of the instruction being accepted
//   rs_q_i        source register of the instruction currently presented
//   rdata_i       RAM read data (address was driven in the previous cycle)
//   wb_en_i, wb_addr_i, wb_data_i  writeback port
//   val_o         operand value presented to execute
module operand_bypass_mux
  import regfile_operand_fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            accept_i,
  input  logic            fresh_i,
  input  logic            hold_en_i,
  input  logic [AW-1:0]   rs_in_i,
  input  logic [AW-1:0]   rs_q_i,
  input  logic [XLEN-1:0] rdata_i,
  input  logic            wb_en_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0] val_o
);

  logic            byp_hit_q, byp_hit_d;
  logic [XLEN-1:0] byp_data_q, byp_data_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic            cap_hit, live_hit;
  logic [XLEN-1:0] base;

  // The RAM returns the old value when it is written on the same edge it is
  // read, so a writeback coinciding with the accept must be captured here.
  assign cap_hit  = wb_en_i && (wb_addr_i == rs_in_i) && (rs_in_i != '0);
  assign live_hit = wb_en_i && (wb_addr_i == rs_q_i) && (rs_q_i != '0);

  assign base  = fresh_i ? (byp_hit_q ? byp_data_q : rdata_i) : hold_q;
  // x0 is hard-wired to zero whatever the RAM or writeback says.
  assign val_o = (rs_q_i == '0) ? '0 : (live_hit ? wb_data_i : base);

  always_comb begin
    byp_hit_d  = byp_hit_q;
    byp_data_d = byp_data_q;
    if (accept_i) begin
      byp_hit_d  = cap_hit;
      byp_data_d = wb_data_i;
    end
  end

  // Holding the presented value covers both the FRESH->HELD capture and any
  // writeback landing while stalled (val_o already reflects the live forward).
  assign hold_d = hold_en_i ? val_o : hold_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
      hold_q     <= '0;
    end else begin
      byp_hit_q  <= byp_hit_d;
      byp_data_q <= byp_data_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: rtl/regfile_operand_fetch.sv
// regfile_operand_fetch: operand-fetch stage in front of a 1-cycle-latency
// dual-read register-file RAM.
//   clk, rstn                 clock, asynchronous active-low reset
//   i_valid/o_ready           decode -> fetch handshake, i_instr/i_pc payload
//   i_flush                   drop held and incoming instruction
//   o_raddr1/o_raddr2         RAM read addresses (rs1/rs2 of i_instr)
//   i_rdata1/i_rdata2         RAM read data, one cycle after the address
//   i_wb_en/i_wb_addr/i_wb_data  writeback (also writes the RAM)
//   o_valid/i_ready           fetch -> execute handshake
//   o_instr/o_pc/o_rs1_val/o_rs2_val  presented instruction and operands
module regfile_operand_fetch
  import regfile_operand_fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [XLEN-1:0]    i_pc,
  input  logic               i_flush,
  output logic [AW-1:0]      o_raddr1,
  output logic [AW-1:0]      o_raddr2,
  input  logic [XLEN-1:0]    i_rdata1,
  input  logic [XLEN-1:0]    i_rdata2,
  input  logic               i_wb_en,
  input  logic [AW-1:0]      i_wb_addr,
  input  logic [XLEN-1:0]    i_wb_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [INSTR_W-1:0] o_instr,
  output logic [XLEN-1:0]    o_pc,
  output logic [XLEN-1:0]    o_rs1_val,
  output logic [XLEN-1:0]    o_rs2_val
);

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]      pc_q, pc_d;
  logic                 accept, fresh, hold_en;

  assign o_raddr1 = i_instr[RS1_LSB +: AW];
  assign o_raddr2 = i_instr[RS2_LSB +: AW];

  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready && !i_flush;
  assign fresh   = (state_q == ST_FRESH);
  assign hold_en = (state_q != ST_EMPTY) && !i_ready && !i_flush;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_EMPTY;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_FRESH;
        ST_FRESH,
        ST_HELD: begin
          if (i_ready) state_d = accept ? ST_FRESH : ST_EMPTY;
          else         state_d = ST_HELD;
        end
        default:       state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    if (accept) begin
      instr_d = i_instr;
      pc_d    = i_pc;
    end
  end

  // Outputs
  always_comb begin
    o_valid = (state_q != ST_EMPTY);
    o_instr = instr_q;
    o_pc    = pc_q;
  end

  operand_bypass_mux #(.XLEN(XLEN), .AW(AW)) u_rs1 (
    .clk       (clk),
    .rstn      (rstn),
    .accept_i  (accept),
    .fresh_i   (fresh),
    .hold_en_i (hold_en),
    .rs_in_i   (i_instr[RS1_LSB +: AW]),
    .rs_q_i    (instr_q[RS1_LSB +: AW]),
    .rdata_i   (i_rdata1),
    .wb_en_i   (i_wb_en),
    .wb_addr_i (i_wb_addr),
    .wb_data_i (i_wb_data),
    .val_o     (o_rs1_val)
  );

  operand_bypass_mux #(.XLEN(XLEN), .AW(AW)) u_rs2 (
    .clk       (clk),
    .rstn      (rstn),
    .accept_i  (accept),
    .fresh_i   (fresh),
    .hold_en_i (hold_en),
    .rs_in_i   (i_instr[RS2_LSB +: AW]),
    .rs_q_i    (instr_q[RS2_LSB +: AW]),
    .rdata_i   (i_rdata2),
    .wb_en_i   (i_wb_en),
    .wb_addr_i (i_wb_addr),
    .wb_data_i (i_wb_data),
    .val_o     (o_rs2_val)
  );

endmodule

// File: tb/tb_regfile_operand_fetch.sv
module tb_regfile_operand_fetch;

  logic        clk;
  logic        rstn;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  logic        i_flush;
  logic [4:0]  o_raddr1, o_raddr2;
  logic [31:0] rdata1, rdata2;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_rs1_val, o_rs2_val;

  int checks = 0;
  int errors = 0;

  // Register-file RAM: synchronous read, read-before-write on the same edge.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (wb_en) mem[wb_addr] <= wb_data;
    rdata1 <= mem[o_raddr1];
    rdata2 <= mem[o_raddr2];
  end

  regfile_operand_fetch dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_instr   (i_instr),
    .i_pc      (i_pc),
    .i_flush   (i_flush),
    .o_raddr1  (o_raddr1),
    .o_raddr2  (o_raddr2),
    .i_rdata1  (rdata1),
    .i_rdata2  (rdata2),
    .i_wb_en   (wb_en),
    .i_wb_addr (wb_addr),
    .i_wb_data (wb_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_instr   (o_instr),
    .o_pc      (o_pc),
    .o_rs1_val (o_rs1_val),
    .o_rs2_val (o_rs2_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  logic [31:0] add_i, sub_i, x0_i, same_i, oth_i;

  initial begin
    add_i  = rtype(7'h00, 5'd7, 5'd5, 5'd6);   // add x7,x5,x6
    sub_i  = rtype(7'h20, 5'd8, 5'd6, 5'd5);   // sub x8,x6,x5
    oth_i  = rtype(7'h20, 5'd9, 5'd1, 5'd2);   // sub x9,x1,x2
    x0_i   = rtype(7'h00, 5'd7, 5'd0, 5'd6);   // add x7,x0,x6
    same_i = rtype(7'h00, 5'd7, 5'd5, 5'd5);   // add x7,x5,x5

    rstn = 1'b0; i_valid = 1'b0; i_instr = '0; i_pc = '0; i_flush = 1'b0;
    i_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;

    // Preload the RAM during reset
    nxt; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h11;
    nxt; wb_addr = 5'd6; wb_data = 32'h22;
    nxt; wb_addr = 5'd0; wb_data = 32'hFFFF;
    nxt; wb_en = 1'b0;
    mid;
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_pc",    o_pc,    32'd0);
    chk("rst_ready", {31'b0, o_ready}, 32'd1);

    // Reset asserted mid-stream
    nxt; rstn = 1'b1;
    i_valid = 1'b1; i_instr = add_i; i_pc = 32'h100;
    nxt; i_valid = 1'b0;
    mid;
    chk("pre_rst_valid", {31'b0, o_valid}, 32'd1);
    chk("pre_rst_instr", o_instr, add_i);
    #1 rstn = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, o_valid}, 32'd0);
    chk("async_rst_instr", o_instr, 32'd0);
    chk("async_rst_pc",    o_pc,    32'd0);
    nxt; rstn = 1'b1;

    // Back-to-back with i_ready high
    i_valid = 1'b1; i_instr = add_i; i_pc = 32'h200;
    mid;
    chk("b2b_not_yet_valid", {31'b0, o_valid}, 32'd0);
    nxt; i_instr = sub_i; i_pc = 32'h204;
    mid;
    chk("b2b0_valid", {31'b0, o_valid}, 32'd1);
    chk("b2b0_instr", o_instr, add_i);
    chk("b2b0_pc",    o_pc,    32'h200);
    chk("b2b0_rs1",   o_rs1_val, 32'h11);
    chk("b2b0_rs2",   o_rs2_val, 32'h22);
    nxt; i_valid = 1'b0;
    mid;
    chk("b2b1_instr", o_instr, sub_i);
    chk("b2b1_pc",    o_pc,    32'h204);
    chk("b2b1_rs1",   o_rs1_val, 32'h22);
    chk("b2b1_rs2",   o_rs2_val, 32'h11);
    nxt;
    mid;
    chk("b2b_drain_valid", {31'b0, o_valid}, 32'd0);

    // Same-edge writeback to rs1 during the accept cycle
    nxt; i_valid = 1'b1; i_instr = add_i; i_pc = 32'h300;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hAA;
    nxt; i_valid = 1'b0; wb_en = 1'b0;
    mid;
    chk("sameedge_rs1", o_rs1_val, 32'hAA);
    chk("sameedge_rs2", o_rs2_val, 32'h22);
    nxt; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h11;
    nxt; wb_en = 1'b0;

    // Stall: execute not ready for three cycles
    i_valid = 1'b1; i_instr = add_i; i_pc = 32'h400;
    nxt; i_ready = 1'b0; i_instr = oth_i; i_pc = 32'h404;
    mid;
    chk("stall0_ready", {31'b0, o_ready}, 32'd0);
    chk("stall0_rs1", o_rs1_val, 32'h11);
    chk("stall0_rs2", o_rs2_val, 32'h22);
    nxt;
    mid;
    chk("stall1_instr", o_instr, add_i);
    chk("stall1_rs1", o_rs1_val, 32'h11);
    chk("stall1_rs2", o_rs2_val, 32'h22);
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h55;
    #1;
    chk("stall_wb_live_rs2", o_rs2_val, 32'h55);
    chk("stall_wb_live_rs1", o_rs1_val, 32'h11);
    nxt; wb_en = 1'b0;
    mid;
    chk("stall2_rs2", o_rs2_val, 32'h55);
    chk("stall2_pc",  o_pc, 32'h400);
    nxt; i_ready = 1'b1; i_valid = 1'b0;
    mid;
    chk("stall_release_valid", {31'b0, o_valid}, 32'd1);
    chk("stall_release_rs1", o_rs1_val, 32'h11);
    chk("stall_release_rs2", o_rs2_val, 32'h55);
    nxt;
    mid;
    chk("stall_drain_valid", {31'b0, o_valid}, 32'd0);
    nxt; wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h22;
    nxt; wb_en = 1'b0;

    // x0 source with RAM[0]=0xFFFF and writebacks to x0
    i_valid = 1'b1; i_instr = x0_i; i_pc = 32'h500;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1;
    nxt; i_valid = 1'b0;
    mid;
    chk("x0_rs1", o_rs1_val, 32'h0);
    chk("x0_rs2", o_rs2_val, 32'h22);
    nxt; wb_en = 1'b0;

    // rs1 == rs2 with a live forward
    i_valid = 1'b1; i_instr = same_i; i_pc = 32'h580;
    nxt; i_valid = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h77;
    mid;
    chk("same_rs1", o_rs1_val, 32'h77);
    chk("same_rs2", o_rs2_val, 32'h77);
    nxt; wb_en = 1'b0;

    // Flush while HELD, with a new instruction offered
    i_valid = 1'b1; i_instr = add_i; i_pc = 32'h600;
    nxt; i_valid = 1'b0; i_ready = 1'b0;
    nxt; i_flush = 1'b1; i_valid = 1'b1; i_instr = sub_i; i_pc = 32'h604;
    mid;
    chk("held_before_flush", {31'b0, o_valid}, 32'd1);
    nxt; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    mid;
    chk("flush_held_valid", {31'b0, o_valid}, 32'd0);
    // Flush in the accept cycle from EMPTY
    nxt; i_flush = 1'b1; i_valid = 1'b1; i_instr = sub_i; i_pc = 32'h608;
    nxt; i_flush = 1'b0; i_valid = 1'b0;
    mid;
    chk("flush_accept_valid", {31'b0, o_valid}, 32'd0);
    chk("flush_accept_pc", o_pc, 32'h600);
    nxt;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
